// File: rtl/lcd_ctrl_win.sv
// rtl/lcd_ctrl_win.sv - LCD image controller: ROM load, window scan/mirror, IRAM dump
module lcd_ctrl_win #(
  parameter int  DW    = 8,
  parameter int  IMG_W = 8,
  parameter int  IMG_H = 8,
  parameter int  WIN   = 4,
  localparam int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_ceb,
  output logic          IRAM_web,
  output logic [AW-1:0] IRAM_A,
  output logic [DW-1:0] IRAM_D,
  input  logic [DW-1:0] IRAM_Q,
  output logic          busy,
  output logic          done,
  output logic          cmd_err
);

  localparam int N    = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int LW   = $clog2(WIN);
  localparam int ACCW = DW + 2 * LW;
  localparam int HALF = WIN / 2;

  localparam logic [AW:0]   CNT_LOAD_END = (AW+1)'(N);
  localparam logic [AW:0]   CNT_WR_LAST  = (AW+1)'(N - 1);
  localparam logic [AW:0]   CNT_SC_LAST  = (AW+1)'(WIN * WIN - 1);
  localparam logic [AW:0]   CNT_MR_LAST  = (AW+1)'(WIN * WIN / 2 - 1);
  localparam logic [XW-1:0] X_MIN = XW'(HALF);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - HALF);
  localparam logic [YW-1:0] Y_MIN = YW'(HALF);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - HALF);

  typedef enum logic [3:0] {
    S_LOAD, S_IDLE, S_SHIFT, S_SCAN, S_APPLY, S_MIRROR, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [XW-1:0]   op_x_q, op_x_d;
  logic [YW-1:0]   op_y_q, op_y_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0]   mem_q [N];

  logic [XW-1:0]   x0;
  logic [YW-1:0]   y0;
  int              idx;
  logic [AW-1:0]   scan_addr, mir_a, mir_b, load_addr;
  logic [ACCW-1:0] pix_ext;
  logic [DW-1:0]   apply_val;
  logic [N-1:0]    win_mask;
  logic            unused_iram;

  assign unused_iram = ^IRAM_Q;

  function automatic logic [AW-1:0] pix_addr(input int x, input int y);
    return AW'(y * IMG_W + x);
  endfunction

  // Window origin is the top-left corner; op point sits just right/below the centre.
  assign x0        = op_x_q - XW'(HALF);
  assign y0        = op_y_q - YW'(HALF);
  assign load_addr = AW'(cnt_q - 1'b1);
  assign pix_ext   = ACCW'(mem_q[scan_addr]);
  assign apply_val = (cmd_q == 4'd7) ? DW'(acc_q >> (2 * LW)) : acc_q[DW-1:0];

  // Scan and mirror-pair addresses derived from the step counter.
  always_comb begin
    idx       = int'(cnt_q);
    scan_addr = pix_addr(int'(x0) + idx % WIN, int'(y0) + idx / WIN);
    if (cmd_q == 4'd8) begin
      mir_a = pix_addr(int'(x0) + idx % HALF, int'(y0) + idx / HALF);
      mir_b = pix_addr(int'(x0) + WIN - 1 - idx % HALF, int'(y0) + idx / HALF);
    end else begin
      mir_a = pix_addr(int'(x0) + idx % WIN, int'(y0) + idx / WIN);
      mir_b = pix_addr(int'(x0) + idx % WIN, int'(y0) + WIN - 1 - idx / WIN);
    end
  end

  // Flags every buffer location that lies inside the current window.
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < N; i++) begin
      win_mask[i] = (i % IMG_W >= int'(x0)) && (i % IMG_W < int'(x0) + WIN) &&
                    (i / IMG_W >= int'(y0)) && (i / IMG_W < int'(y0) + WIN);
    end
  end

  // State register and control counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      cmd_q   <= '0;
      op_x_q  <= XW'(IMG_W / 2);
      op_y_q  <= YW'(IMG_H / 2);
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic: command decode, point moves and window reduction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op_x_d  = op_x_q;
    op_y_d  = op_y_q;
    acc_d   = acc_q;
    case (state_q)
      S_LOAD: begin
        if (cnt_q == CNT_LOAD_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d = cmd;
          cnt_d = '0;
          case (cmd)
            4'd0:                   state_d = S_WRITE;
            4'd1, 4'd2, 4'd3, 4'd4: state_d = S_SHIFT;
            4'd5, 4'd6, 4'd7:       state_d = S_SCAN;
            4'd8, 4'd9:             state_d = S_MIRROR;
            default:                state_d = S_ERR;
          endcase
        end
      end
      S_SHIFT: begin
        case (cmd_q)
          4'd1:    if (op_y_q > Y_MIN) op_y_d = op_y_q - 1'b1;
          4'd2:    if (op_y_q < Y_MAX) op_y_d = op_y_q + 1'b1;
          4'd3:    if (op_x_q > X_MIN) op_x_d = op_x_q - 1'b1;
          default: if (op_x_q < X_MAX) op_x_d = op_x_q + 1'b1;
        endcase
        state_d = S_IDLE;
      end
      S_SCAN: begin
        if (cnt_q == '0) begin
          acc_d = pix_ext;
        end else begin
          case (cmd_q)
            4'd5:    if (pix_ext > acc_q) acc_d = pix_ext;
            4'd6:    if (pix_ext < acc_q) acc_d = pix_ext;
            default: acc_d = acc_q + pix_ext;
          endcase
        end
        if (cnt_q == CNT_SC_LAST) begin
          state_d = S_APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_APPLY: state_d = S_IDLE;
      S_MIRROR: begin
        if (cnt_q == CNT_MR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == CNT_WR_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; held at idle values while reset is asserted so no stray access leaks out.
  always_comb begin
    IROM_rd  = 1'b0;
    IROM_A   = '0;
    IRAM_ceb = 1'b0;
    IRAM_web = 1'b1;
    IRAM_A   = '0;
    IRAM_D   = '0;
    busy     = 1'b1;
    done     = 1'b0;
    cmd_err  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_LOAD: begin
          if (cnt_q < CNT_LOAD_END) begin
            IROM_rd = 1'b1;
            IROM_A  = cnt_q[AW-1:0];
          end
        end
        S_IDLE: busy = 1'b0;
        S_WRITE: begin
          IRAM_ceb = 1'b1;
          IRAM_web = 1'b0;
          IRAM_A   = cnt_q[AW-1:0];
          IRAM_D   = mem_q[cnt_q[AW-1:0]];
        end
        S_DONE:  done    = 1'b1;
        S_ERR:   cmd_err = 1'b1;
        default: ;
      endcase
    end
  end

  // Image buffer: ROM capture, window fill and pairwise mirror swaps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state_q)
        S_LOAD: if (cnt_q != '0) mem_q[load_addr] <= IROM_Q;
        S_APPLY: begin
          for (int i = 0; i < N; i++) begin
            if (win_mask[i]) mem_q[i] <= apply_val;
          end
        end
        S_MIRROR: begin
          mem_q[mir_a] <= mem_q[mir_b];
          mem_q[mir_b] <= mem_q[mir_a];
        end
        default: ;
      endcase
    end
  end

endmodule
